// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the dual-issue front end.
// Optional perf counters in dual_issue_sequencer are enabled by DUAL_ISSUE_PERF_CNT_EN.
package bsg_vanilla_pkg;

  // Instruction width that instr_pair_s is built for.
  localparam int unsigned di_instr_width_gp = 32;

  // Sequencer state: nothing held, pair held with slot 0 pending, slot 1 pending.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PAIR   = 2'd1,
    SECOND = 2'd2
  } dual_issue_state_e;

  // One fetched pair. second_v is low when slot 1 holds no real instruction.
  typedef struct packed {
    logic [1:0][di_instr_width_gp-1:0] instr;
    logic                              second_v;
  } instr_pair_s;

endpackage

// File: rtl/dual_issue_perf_ctr.sv
// Saturating event counter. Clears on reset and sticks at all-ones.
module dual_issue_perf_ctr #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  output logic [width_p-1:0] cnt_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  // Next count: step on each event unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + width_p'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dual_issue_sequencer.sv
// Holds one fetched instruction pair and sequences it into decode, either as a
// dual issue or as slot 0 then slot 1. Owns fetch backpressure, per-slot PC and
// flush. Defining DUAL_ISSUE_PERF_CNT_EN adds dual/single/stall counters.
module dual_issue_sequencer
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned pc_width_p       = 32,
  parameter int unsigned instr_width_p    = 32,
  parameter int unsigned perf_cnt_width_p = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          fetch_v_i,
  input  logic [1:0][instr_width_p-1:0] fetch_instr_i,
  input  logic [pc_width_p-1:0]         fetch_pc_i,
  input  logic                          fetch_second_v_i,
  output logic                          fetch_ready_o,
  input  logic                          single_issue_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  output logic [1:0][instr_width_p-1:0] instr_o,
  output logic                          issue_v_o,
  output logic                          issue_dual_o,
  output logic                          issue_slot_o,
  output logic [pc_width_p-1:0]         issue_pc_o
`ifdef DUAL_ISSUE_PERF_CNT_EN
  ,
  output logic [perf_cnt_width_p-1:0]   dual_cnt_o,
  output logic [perf_cnt_width_p-1:0]   single_cnt_o,
  output logic [perf_cnt_width_p-1:0]   stall_cnt_o
`endif
);

  dual_issue_state_e state_q, state_d;

  logic [1:0][instr_width_p-1:0] instr_q;
  logic [pc_width_p-1:0]         pc_q;
  logic                          second_v_q;

  logic                  issue_v_s;
  logic                  issue_dual_s;
  logic                  issue_slot_s;
  logic [pc_width_p-1:0] issue_pc_s;
  logic                  fetch_ready_s;
  logic                  fire_s;
  logic                  to_second_s;
  logic                  complete_s;
  logic                  capture_s;

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins, then a new capture, then slot-1 hand-off, then drain.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (capture_s) begin
      state_d = PAIR;
    end else if (to_second_s) begin
      state_d = SECOND;
    end else if (complete_s) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Issue offer, fire/completion and fetch handshake for the current state.
  always_comb begin
    issue_v_s    = 1'b0;
    issue_dual_s = 1'b0;
    issue_slot_s = 1'b0;
    issue_pc_s   = '0;
    case (state_q)
      EMPTY: begin
        issue_v_s = 1'b0;
      end
      PAIR: begin
        issue_v_s  = ~flush_i;
        issue_pc_s = pc_q;
        // A lone slot 0 or a split verdict issues slot 0 alone.
        if (second_v_q && !single_issue_i) begin
          issue_dual_s = 1'b1;
        end else begin
          issue_dual_s = 1'b0;
        end
      end
      SECOND: begin
        issue_v_s    = ~flush_i;
        issue_slot_s = 1'b1;
        issue_pc_s   = pc_q + pc_width_p'(3'd4);
      end
      default: begin
        issue_v_s = 1'b0;
      end
    endcase

    fire_s      = issue_v_s & ~stall_i & ~flush_i;
    to_second_s = fire_s & (state_q == PAIR) & second_v_q & single_issue_i;
    complete_s  = fire_s & ~to_second_s;

    if (state_q == EMPTY) begin
      fetch_ready_s = ~flush_i;
    end else begin
      fetch_ready_s = complete_s;
    end
    capture_s = fetch_v_i & fetch_ready_s;
  end

  // Held pair, PC and slot-1 validity; loaded only on an accepted fetch.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      instr_q    <= '0;
      pc_q       <= '0;
      second_v_q <= 1'b0;
    end else if (capture_s) begin
      instr_q    <= fetch_instr_i;
      pc_q       <= fetch_pc_i;
      second_v_q <= fetch_second_v_i;
    end else begin
      instr_q    <= instr_q;
      pc_q       <= pc_q;
      second_v_q <= second_v_q;
    end
  end

  assign fetch_ready_o = fetch_ready_s;
  assign instr_o       = instr_q;
  assign issue_v_o     = issue_v_s;
  assign issue_dual_o  = issue_dual_s;
  assign issue_slot_o  = issue_slot_s;
  assign issue_pc_o    = issue_pc_s;

`ifdef DUAL_ISSUE_PERF_CNT_EN
  logic dual_fire_s;
  logic single_fire_s;
  logic stall_evt_s;

  assign dual_fire_s   = fire_s & issue_dual_s;
  assign single_fire_s = fire_s & ~issue_dual_s;
  assign stall_evt_s   = issue_v_s & stall_i;

  dual_issue_perf_ctr #(.width_p(perf_cnt_width_p)) u_dual_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (dual_fire_s),
    .cnt_o    (dual_cnt_o)
  );

  dual_issue_perf_ctr #(.width_p(perf_cnt_width_p)) u_single_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (single_fire_s),
    .cnt_o    (single_cnt_o)
  );

  dual_issue_perf_ctr #(.width_p(perf_cnt_width_p)) u_stall_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (stall_evt_s),
    .cnt_o    (stall_cnt_o)
  );
`endif

endmodule
